pwm_duty_ctrl: RTL
==================

Name: pwm_duty_ctrl

Overview:
- Duty-cycle controller and PWM generator for the PWM practice datapath.
- Sequences a 0–100 % duty value, either manually (up/down buttons) or as an automatic triangle sweep.
- Derives its own PWM-count and duty-step enables from the 50 MHz board clock, so the same clock-division scheme runs as single-clock enables.
- Drives the PWM output. Duty changes are applied only on PWM period boundaries, so the output never glitches.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- PWM_FREQ, 1000, PWM period frequency in Hz. One period is 100 counts.
- STEP_FREQ, 20, rate in Hz at which sweep mode advances the duty.
- DUTY_STEP, 10, duty increment per step, in percent, range 1..100.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  synchronous, active-low reset.
- en  input  1  1 = controller running; 0 = IDLE.
- mode  input  1  0 = manual, 1 = automatic sweep.
- btn_up  input  1  increase duty. Already synchronized and debounced; level input, edge-detected internally.
- btn_down  input  1  decrease duty. Same conditioning as btn_up.
- duty  output  7  currently applied duty, 0..100.
- state  output  2  FSM state encoding, for LEDs/debug.
- pwm_out  output  1  PWM waveform.

Behaviour:
- Clock and reset:
  - One clock, clk. rst is synchronous and active-low.
  - While rst=0 on a rising edge: all counters = 0, duty_req = 0, duty = 0, pwm_out = 0, state = IDLE, edge-detect registers = 0.
  - Reset asserted mid-period aborts the period immediately. There is no partial pulse after release.
- Enables:
  - cnt_tick: single-cycle pulse every CNT_DIV = CLK_FREQ/(PWM_FREQ*100) clocks (prescaler counts 0..CNT_DIV-1).
  - pwm_cnt (7 bit) advances on cnt_tick, 0..99, then wraps to 0. The wrap cycle is the period boundary (pb).
  - step_tick: single-cycle pulse every CLK_FREQ/STEP_FREQ clocks. Its prescaler is free-running while en=1 and is cleared while in IDLE.
- FSM states: IDLE=0, MANUAL=1, SWEEP_UP=2, SWEEP_DOWN=3. State is registered.
  - IDLE: en=1 & mode=0 -> MANUAL; en=1 & mode=1 -> SWEEP_UP.
  - Any state with en=0 -> IDLE on the next clock.
  - MANUAL with mode=1 -> SWEEP_UP.
  - SWEEP_UP/SWEEP_DOWN with mode=0 -> MANUAL. duty_req is held.
  - SWEEP_UP: on step_tick, duty_req = min(duty_req+DUTY_STEP, 100). If the result is 100 -> SWEEP_DOWN.
  - SWEEP_DOWN: on step_tick, duty_req = max(duty_req-DUTY_STEP, 0). If the result is 0 -> SWEEP_UP.
- Manual mode:
  - Rising edge of btn_up adds DUTY_STEP to duty_req, saturating at 100.
  - Rising edge of btn_down subtracts DUTY_STEP from duty_req, saturating at 0.
  - Both rising edges in the same cycle: no change.
  - Button edges are ignored in IDLE and sweep states.
- Arithmetic:
  - Saturation is computed in 8 bits, so there is no wrap-around.
  - 0 - DUTY_STEP gives 0; 95 + 10 gives 100.
- Shadow duty register:
  - duty (the output) loads duty_req only on pb, so latency from request to effect is up to one PWM period.
  - In IDLE, duty keeps its last value.
- PWM output:
  - pwm_out is registered: pwm_out = (state != IDLE) & (pwm_cnt < duty).
  - duty=0 gives constant 0; duty=100 gives constant 1.
  - pwm_out falls to 0 one clock after entering IDLE.

Decomposition:
- Shared package pwm_pkg:
  - state encoding constants (IDLE, MANUAL, SWEEP_UP, SWEEP_DOWN);
  - DUTY_MAX = 100;
  - PWM_STEPS = 100.
- One sub-module, pwm_tick_gen:
  - parameter DIV;
  - ports clk, rst, clr, tick;
  - single-cycle pulse every DIV clocks;
  - instantiated twice, once for cnt_tick and once for step_tick.

Test Plan:
- All scenarios run with CLK_FREQ=10_000, PWM_FREQ=10, STEP_FREQ=5, DUTY_STEP=10. This gives CNT_DIV=10, a 1000-clock PWM period and a 2000-clock step.
- Reset: hold rst=0 for 5 clocks with en=1, mode=1 -> duty=0, pwm_out=0, state=0. After release, state=2 on the next clock.
- Manual: en=1, mode=0, three btn_up pulses -> duty=30 after the next pb. pwm_out is high for 300 clocks of each 1000-clock period.
- Saturation: twelve btn_up pulses -> duty=100, pwm_out constant 1. Then a simultaneous up+down pulse -> duty stays 100. Then eleven btn_down pulses -> duty=0, pwm_out constant 0.
- Sweep: mode=1 from duty 0 -> duty steps 10, 20 … 100 every 2000 clocks, with state going 2 -> 3 at 100. Duty then descends to 0 and state returns to 2.
- Glitch-free update: btn_up mid-period (pwm_cnt=50, duty 30->40) -> the current period still has a 300-clock high time; the next period has 400.
- Disable/reset mid-operation: deassert en during a high pulse -> pwm_out=0 one clock later, state=0, duty held. Assert rst mid-sweep -> everything zero the next clock.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty controller.
// Holds the state encoding, duty limits and saturating arithmetic.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MANUAL     = 2'd1,
    SWEEP_UP   = 2'd2,
    SWEEP_DOWN = 2'd3
  } state_e;

  localparam int DUTY_MAX  = 100;
  localparam int PWM_STEPS = 100;

  // Widened to 8 bits so neither direction can wrap.
  function automatic logic [6:0] sat_add(
    input logic [6:0] a,
    input logic [6:0] s
  );
    logic [7:0] t;
    t = {1'b0, a} + {1'b0, s};
    return (t > 8'(DUTY_MAX)) ? 7'(DUTY_MAX) : t[6:0];
  endfunction

  function automatic logic [6:0] sat_sub(
    input logic [6:0] a,
    input logic [6:0] s
  );
    logic [7:0] t;
    t = {1'b0, a} - {1'b0, s};
    return (a < s) ? 7'd0 : t[6:0];
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler producing a single-cycle enable pulse every DIV clocks.
// clr holds the count at zero and suppresses the pulse.
module pwm_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty sequencer (manual buttons or triangle sweep) and PWM generator.
// The applied duty is shadowed and only reloaded on period boundaries.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int PWM_FREQ  = 1000,
  parameter int STEP_FREQ = 20,
  parameter int DUTY_STEP = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [6:0] duty,
  output logic [1:0] state,
  output logic       pwm_out
);

  localparam int CNT_DIV  = CLK_FREQ / (PWM_FREQ * PWM_STEPS);
  localparam int STEP_DIV = CLK_FREQ / STEP_FREQ;
  localparam logic [6:0] STEP = 7'(DUTY_STEP);
  localparam logic [6:0] CMAX = 7'(PWM_STEPS - 1);

  state_e     state_q, state_d;
  logic [6:0] req_q, req_d;
  logic [6:0] duty_q, duty_d;
  logic [6:0] pcnt_q, pcnt_d;
  logic       pwm_q, pwm_d;
  logic       up_q, dn_q;

  logic       cnt_tick, step_tick, pb;
  logic       up_rise, dn_rise;
  logic [6:0] inc, dec;

  pwm_tick_gen #(.DIV(CNT_DIV)) u_cnt_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .tick (cnt_tick)
  );

  pwm_tick_gen #(.DIV(STEP_DIV)) u_step_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .tick (step_tick)
  );

  assign up_rise = btn_up & ~up_q;
  assign dn_rise = btn_down & ~dn_q;
  assign inc     = sat_add(req_q, STEP);
  assign dec     = sat_sub(req_q, STEP);
  assign pb      = cnt_tick && (pcnt_q == CMAX);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = mode ? SWEEP_UP : MANUAL;
        end
        MANUAL: begin
          if (mode) begin
            state_d = SWEEP_UP;
          end else if (up_rise && !dn_rise) begin
            req_d = inc;
          end else if (dn_rise && !up_rise) begin
            req_d = dec;
          end
        end
        SWEEP_UP: begin
          if (!mode) begin
            state_d = MANUAL;
          end else if (step_tick) begin
            req_d = inc;
            if (inc == 7'(DUTY_MAX)) state_d = SWEEP_DOWN;
          end
        end
        SWEEP_DOWN: begin
          if (!mode) begin
            state_d = MANUAL;
          end else if (step_tick) begin
            req_d = dec;
            if (dec == 7'd0) state_d = SWEEP_UP;
          end
        end
      endcase
    end
  end

  always_comb begin
    pcnt_d = pcnt_q;
    if (cnt_tick) begin
      pcnt_d = (pcnt_q == CMAX) ? 7'd0 : pcnt_q + 7'd1;
    end
    duty_d = duty_q;
    if (pb && state_q != IDLE) begin
      duty_d = req_q;
    end
    pwm_d = (state_q != IDLE) && (pcnt_q < duty_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      duty_q  <= '0;
      pcnt_q  <= '0;
      pwm_q   <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      duty_q  <= duty_d;
      pcnt_q  <= pcnt_d;
      pwm_q   <= pwm_d;
      up_q    <= btn_up;
      dn_q    <= btn_down;
    end
  end

  assign duty    = duty_q;
  assign state   = state_q;
  assign pwm_out = pwm_q;

endmodule
